lz77_stream_encoder: RTL and testbench
======================================

# lz77_stream_encoder

Parametrised, streaming successor to the fixed-length LZ77 encoder. Accepts symbols over a valid/ready handshake with an explicit end-of-stream flag. Emits (offset, match_len, char_nxt) tokens over a back-pressurable valid/ready output. Search depth, lookahead depth and symbol width are generics. It sits between the symbol source and the token packer in the compression path.

## Interface
- SYM_W, 8, symbol width in bits
- SEARCH_W, 9, search (history) window depth in symbols
- LA_W, 8, lookahead buffer depth; max match length is LA_W-1
- OFF_W, $clog2(SEARCH_W), offset field width
- LEN_W, $clog2(LA_W), match_len field width
- END_CHAR, 8'h24, end-of-stream marker symbol (SYM_W bits)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  input symbol valid
- in_ready  out  1  encoder accepts symbol this cycle
- in_data  in  SYM_W  input symbol
- in_last  in  1  qualifies in_data as final symbol of stream
- out_valid  out  1  token valid
- out_ready  in  1  downstream accepts token
- offset  out  OFF_W  match distance minus 1 (0 = most recent history symbol)
- match_len  out  LEN_W  matched symbol count
- char_nxt  out  SYM_W  literal following the match
- finish  out  1  stream fully encoded; sticky until reset

## Operation
- State machine: FILL, SEARCH, EMIT, SHIFT, DONE.
- FILL:
  - in_ready=1; each in_valid&in_ready appends to lookahead (la_count++); in_last sets last_seen.
  - Exit to SEARCH when la_count==LA_W or (last_seen and la_count>0).
- SEARCH: tests candidate offsets o=0..SEARCH_W-1, one per cycle.
  - Candidates with o>=hist_count are invalid.
  - Candidate symbol i is hist[o-i] if i<=o, else la[i-o-1]; overlap into the lookahead is legal.
  - Length is the count of leading equal symbols, capped at max_len.
  - A candidate is kept only if strictly longer than the current best, so ties resolve to the smaller offset.
  - max_len = min(LA_W-1, la_count-1). With the macro enabled and last_seen, it is min(LA_W-1, la_count).
- EMIT:
  - out_valid=1; offset, match_len and char_nxt stay stable until out_ready.
  - char_nxt = la[match_len], or END_CHAR when match_len==la_count (macro only).
- SHIFT:
  - Moves consumed symbols (match_len+1, or match_len when END_CHAR was used) from lookahead into history, one per cycle.
  - hist_count saturates at SEARCH_W; the oldest history symbol is dropped.
  - Then: if la_count==0 and last_seen, go to DONE (or to the END token, see Configuration).
  - Else if last_seen or la_count==LA_W, go to SEARCH; else go to FILL.
- DONE: finish=1, in_ready=0, out_valid=0 until reset.
- in_ready=0 in all states except FILL.

## Timing
- Reset values: in_ready=0, out_valid=0, offset=0, match_len=0, char_nxt=0, finish=0. Buffers and counters are cleared.
- in_ready rises the first cycle after reset deasserts.
- SEARCH lasts exactly SEARCH_W cycles.
- out_valid rises the cycle after SEARCH ends.
- Token handshake completes on the edge where out_valid&out_ready; out_valid falls the next cycle. Token fields hold their last values.
- SHIFT lasts (symbols consumed) cycles, minimum 1.
- finish rises the cycle after the final SHIFT (or final END-token handshake).
- Reset asserted in any state aborts immediately. A partial token is never re-emitted.
- in_valid while in_ready=0 is ignored; the source holds the symbol.

## Configuration
- LZ77_END_MARKER_EN defined:
  - The final token carries char_nxt=END_CHAR and covers all remaining symbols via match_len.
  - If the last data symbol was consumed as a literal, an extra token (0,0,END_CHAR) is emitted before finish.
- Undefined: no END_CHAR is ever emitted; the final token's char_nxt is the last data symbol; finish follows the last data token.

## Test plan
- Reset: hold reset 3 cycles, release -> all outputs 0; in_ready=1 next cycle; finish=0.
- Nine 0x41 symbols, in_last on ninth:
  - Tokens (0,0,0x41) then (0,7,0x41).
  - With macro: then (0,0,0x24), finish=1.
  - Without macro: finish=1 after the second token.
- "ABCABC", in_last on final C:
  - Tokens (0,0,'A'), (0,0,'B'), (0,0,'C').
  - Then with macro: (2,3,0x24); without macro: (2,2,'C').
  - finish=1.
- Back-pressure: hold out_ready=0 for 5 cycles on every token of "ABCABC" -> fields stable while out_valid=1, in_ready=0, token sequence identical to the previous test.
- Single symbol 0x5A with in_last -> (0,0,0x5A); macro adds (0,0,0x24); finish=1; in_ready stays 0 afterwards.
- Reset mid-SEARCH of the "ABCABC" run, then resend "ABCABC" -> first token is again (0,0,'A'), with no stale history matches.

Source files
------------

// File: rtl/lz77_stream_encoder.sv
// Streaming LZ77 encoder: symbols in over valid/ready, (offset, match_len, char_nxt) tokens out.
// Define LZ77_END_MARKER_EN to make the final token carry END_CHAR (plus a trailing END token if needed).
module lz77_stream_encoder #(
  parameter int SYM_W    = 8,
  parameter int SEARCH_W = 9,
  parameter int LA_W     = 8,
  parameter int OFF_W    = $clog2(SEARCH_W),
  parameter int LEN_W    = $clog2(LA_W),
  parameter logic [SYM_W-1:0] END_CHAR = 8'h24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [SYM_W-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OFF_W-1:0] offset_o,
  output logic [LEN_W-1:0] match_len_o,
  output logic [SYM_W-1:0] char_nxt_o,
  output logic             finish_o
);

`ifdef LZ77_END_MARKER_EN
  localparam bit END_TOKEN_ON = 1'b1;
`else
  localparam bit END_TOKEN_ON = 1'b0;
`endif
  localparam int LA_CNT_W   = $clog2(LA_W + 1);
  localparam int HIST_CNT_W = $clog2(SEARCH_W + 1);

  typedef enum logic [2:0] {FILL, SEARCH, EMIT, SHIFT, END_TOK, DONE} state_e;

  state_e state_q, state_d;

  logic [LA_W-1:0][SYM_W-1:0]     la_q;
  logic [SEARCH_W-1:0][SYM_W-1:0] hist_q;
  logic [LA_CNT_W-1:0]            la_cnt_q;
  logic [HIST_CNT_W-1:0]          hist_cnt_q;
  logic                           last_seen_q;
  logic [OFF_W-1:0]               srch_idx_q;
  logic [OFF_W-1:0]               best_off_q;
  logic [LEN_W-1:0]               best_len_q;
  logic [LA_CNT_W-1:0]            shift_cnt_q;
  logic                           end_used_q;
  logic                           in_ready_q, out_valid_q, finish_q;
  logic [OFF_W-1:0]               offset_q;
  logic [LEN_W-1:0]               len_q;
  logic [SYM_W-1:0]               char_q;

  logic             accept, tok_hs;
  logic [LEN_W-1:0] cand_len, fin_len;
  logic [OFF_W-1:0] fin_off;
  logic             cand_ok, use_end;

  assign accept = in_ready_q & in_valid_i;
  assign tok_hs = out_valid_q & out_ready_i;

  // Candidate o walks back o+1 symbols into history and may run on into the lookahead itself.
  always_comb begin
    int la_cnt_int;
    int max_len;
    int src;
    logic run;
    logic [SYM_W-1:0] cand_sym;
    la_cnt_int = int'(la_cnt_q);
    max_len    = la_cnt_int - 1;
    if (END_TOKEN_ON && last_seen_q) max_len = la_cnt_int;
    if (max_len > LA_W - 1) max_len = LA_W - 1;
    cand_len = '0;
    run      = 1'b1;
    src      = 0;
    cand_sym = '0;
    for (int i = 0; i < LA_W - 1; i++) begin
      if (i <= int'(srch_idx_q)) begin
        src      = int'(srch_idx_q) - i;
        cand_sym = hist_q[OFF_W'(src)];
      end else begin
        src      = i - int'(srch_idx_q) - 1;
        cand_sym = la_q[LEN_W'(src)];
      end
      if (run && i < max_len && cand_sym == la_q[LEN_W'(i)]) cand_len = cand_len + LEN_W'(1);
      else run = 1'b0;
    end
    cand_ok = (int'(srch_idx_q) < int'(hist_cnt_q)) && (cand_len > best_len_q);
    fin_len = cand_ok ? cand_len : best_len_q;
    fin_off = cand_ok ? srch_idx_q : best_off_q;
    use_end = END_TOKEN_ON && (int'(fin_len) == la_cnt_int);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && (in_last_i || la_cnt_q == LA_CNT_W'(LA_W - 1))) state_d = SEARCH;
      SEARCH:  if (srch_idx_q == OFF_W'(SEARCH_W - 1)) state_d = EMIT;
      EMIT:    if (tok_hs) state_d = SHIFT;
      SHIFT: begin
        if (shift_cnt_q == LA_CNT_W'(1)) begin
          if (la_cnt_q == LA_CNT_W'(1) && last_seen_q)
            state_d = (end_used_q || !END_TOKEN_ON) ? DONE : END_TOK;
          else if (last_seen_q)
            state_d = SEARCH;
          else
            state_d = FILL;
        end
      end
      END_TOK: if (tok_hs) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = FILL;
    endcase
  end

  // Handshake flags are registered from the next state so they are all low while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == FILL);
      out_valid_q <= (state_d == EMIT) || (state_d == END_TOK);
      finish_q    <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      la_q        <= '0;
      hist_q      <= '0;
      la_cnt_q    <= '0;
      hist_cnt_q  <= '0;
      last_seen_q <= 1'b0;
      srch_idx_q  <= '0;
      best_off_q  <= '0;
      best_len_q  <= '0;
      shift_cnt_q <= '0;
      end_used_q  <= 1'b0;
      offset_q    <= '0;
      len_q       <= '0;
      char_q      <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            la_q[LEN_W'(la_cnt_q)] <= in_data_i;
            la_cnt_q <= la_cnt_q + LA_CNT_W'(1);
            if (in_last_i) last_seen_q <= 1'b1;
          end
        end
        SEARCH: begin
          srch_idx_q <= srch_idx_q + OFF_W'(1);
          best_len_q <= fin_len;
          best_off_q <= fin_off;
          if (srch_idx_q == OFF_W'(SEARCH_W - 1)) begin
            offset_q    <= fin_off;
            len_q       <= fin_len;
            char_q      <= use_end ? END_CHAR : la_q[fin_len];
            shift_cnt_q <= LA_CNT_W'(fin_len) + (use_end ? LA_CNT_W'(0) : LA_CNT_W'(1));
            end_used_q  <= use_end;
          end
        end
        SHIFT: begin
          hist_q      <= {hist_q[SEARCH_W-2:0], la_q[0]};
          la_q        <= {SYM_W'(0), la_q[LA_W-1:1]};
          la_cnt_q    <= la_cnt_q - LA_CNT_W'(1);
          shift_cnt_q <= shift_cnt_q - LA_CNT_W'(1);
          if (hist_cnt_q != HIST_CNT_W'(SEARCH_W)) hist_cnt_q <= hist_cnt_q + HIST_CNT_W'(1);
          if (state_d == END_TOK) begin
            offset_q <= '0;
            len_q    <= '0;
            char_q   <= END_CHAR;
          end
        end
        default: ;
      endcase
      if (state_d == SEARCH && state_q != SEARCH) begin
        srch_idx_q <= '0;
        best_len_q <= '0;
        best_off_q <= '0;
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign finish_o    = finish_q;
  assign offset_o    = offset_q;
  assign match_len_o = len_q;
  assign char_nxt_o  = char_q;

endmodule

// File: tb/tb_lz77_stream_encoder.sv
// Bench for lz77_stream_encoder: directed and random streams compared against a whole-stream LZ77 model.
// Honours LZ77_END_MARKER_EN the same way the design does.
module tb_lz77_stream_encoder;

  localparam int SEARCH_W = 9;
  localparam int LA_W     = 8;
  localparam int OFF_W    = 4;
  localparam int LEN_W    = 3;
  localparam logic [7:0] END_CHAR = 8'h24;
`ifdef LZ77_END_MARKER_EN
  localparam bit END_ON = 1'b1;
`else
  localparam bit END_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             inValid = 1'b0;
  logic             inReady;
  logic [7:0]       inData = '0;
  logic             inLast = 1'b0;
  logic             outValid;
  logic             outReady = 1'b0;
  logic [OFF_W-1:0] offset;
  logic [LEN_W-1:0] matchLen;
  logic [7:0]       charNxt;
  logic             finish;

  int total = 0;
  int bad   = 0;
  logic [7:0]  streamQ[$];
  logic [31:0] expQ[$];

  always #5 clk = ~clk;

  lz77_stream_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .in_data_i   (inData),
    .in_last_i   (inLast),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .offset_o    (offset),
    .match_len_o (matchLen),
    .char_nxt_o  (charNxt),
    .finish_o    (finish)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] packTok(input int off, input int len, input logic [7:0] ch);
    return {17'd0, OFF_W'(off), LEN_W'(len), ch};
  endfunction

  // Lookahead always holds the next min(LA_W, remaining) symbols; history is the last SEARCH_W consumed.
  function automatic void buildModel();
    int n, p, laCnt, histCnt, maxLen, bestLen, bestOff, len, consumed;
    bit lastSeen, endUsed;
    logic [7:0] ch;
    n = streamQ.size();
    p = 0;
    endUsed = 1'b0;
    expQ.delete();
    while (p < n) begin
      laCnt    = (n - p < LA_W) ? n - p : LA_W;
      lastSeen = (p + laCnt == n);
      histCnt  = (p < SEARCH_W) ? p : SEARCH_W;
      maxLen   = (END_ON && lastSeen) ? laCnt : laCnt - 1;
      if (maxLen > LA_W - 1) maxLen = LA_W - 1;
      bestLen = 0;
      bestOff = 0;
      for (int o = 0; o < histCnt; o++) begin
        len = 0;
        while (len < maxLen && streamQ[p - 1 - o + len] == streamQ[p + len]) len++;
        if (len > bestLen) begin
          bestLen = len;
          bestOff = o;
        end
      end
      endUsed  = END_ON && (bestLen == laCnt);
      ch       = endUsed ? END_CHAR : streamQ[p + bestLen];
      consumed = endUsed ? bestLen : bestLen + 1;
      expQ.push_back(packTok(bestOff, bestLen, ch));
      p += consumed;
    end
    if (END_ON && !endUsed) expQ.push_back(packTok(0, 0, END_CHAR));
  endfunction

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    inValid = 1'b0;
    inLast = 1'b0;
    outReady = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("rstInReady", inReady, 0);
    checkOutput("rstOutValid", outValid, 0);
    checkOutput("rstOffset", offset, 0);
    checkOutput("rstMatchLen", matchLen, 0);
    checkOutput("rstCharNxt", charNxt, 0);
    checkOutput("rstFinish", finish, 0);
    @(negedge clk);
    checkOutput("inReadyRise", inReady, 1);
  endtask

  task automatic applyStimulus(input int gapMax);
    int waited;
    int gap;
    for (int i = 0; i < streamQ.size(); i++) begin
      gap = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
      inValid = 1'b0;
      repeat (gap) @(negedge clk);
      inValid = 1'b1;
      inData  = streamQ[i];
      inLast  = (i == streamQ.size() - 1);
      waited  = 0;
      while (!inReady && waited < 500) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("inReadyWait", inReady, 1);
      if (!inReady) break;
      @(negedge clk);
    end
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  // holdMode < 0 picks a random stall per token; otherwise out_ready stays low that many cycles.
  task automatic collectTokens(input int holdMode);
    int cycles = 0;
    int tokIdx = 0;
    int hold = 0;
    bit pending = 1'b0;
    logic [31:0] curTok, expTok;
    outReady = 1'b0;
    while (!finish && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      if (outValid) begin
        curTok = packTok(int'(offset), int'(matchLen), charNxt);
        expTok = (tokIdx < expQ.size()) ? expQ[tokIdx] : 32'hFFFF_FFFF;
        checkOutput($sformatf("tok%0d", tokIdx), curTok, expTok);
        checkOutput("inReadyLowDuringToken", inReady, 0);
        if (!pending) begin
          pending = 1'b1;
          hold = (holdMode < 0) ? int'($urandom_range(0, 3)) : holdMode;
        end
        if (hold == 0) begin
          outReady = 1'b1;
          tokIdx++;
          pending = 1'b0;
        end else begin
          outReady = 1'b0;
          hold--;
        end
      end else begin
        outReady = 1'b0;
      end
    end
    outReady = 1'b0;
    checkOutput("finishReached", finish, 1);
    checkOutput("tokCount", tokIdx, expQ.size());
  endtask

  task automatic runCase(input int holdMode, input int gapMax);
    buildModel();
    fork
      applyStimulus(gapMax);
      collectTokens(holdMode);
    join
    checkOutput("doneOutValid", outValid, 0);
    checkOutput("doneInReady", inReady, 0);
    repeat (3) @(negedge clk);
    checkOutput("finishSticky", finish, 1);
    checkOutput("doneInReadyHeld", inReady, 0);
  endtask

  task automatic setAbc();
    logic [7:0] abc[6];
    abc = '{8'h41, 8'h42, 8'h43, 8'h41, 8'h42, 8'h43};
    streamQ = {};
    foreach (abc[k]) streamQ.push_back(abc[k]);
  endtask

  initial begin
    int n;
    applyReset();
    streamQ = {};
    repeat (9) streamQ.push_back(8'h41);
    runCase(0, 0);

    applyReset();
    setAbc();
    runCase(0, 0);

    applyReset();
    setAbc();
    runCase(5, 0);

    applyReset();
    streamQ = {};
    streamQ.push_back(8'h5A);
    runCase(0, 0);

    // Abort while the encoder is searching, then make sure nothing from the old run leaks through.
    applyReset();
    setAbc();
    outReady = 1'b0;
    applyStimulus(0);
    repeat (3) @(negedge clk);
    checkOutput("midSearchOutValid", outValid, 0);
    checkOutput("midSearchInReady", inReady, 0);
    applyReset();
    setAbc();
    runCase(0, 0);

    for (int t = 0; t < 8; t++) begin
      applyReset();
      streamQ = {};
      n = int'($urandom_range(1, 24));
      for (int k = 0; k < n; k++) streamQ.push_back(8'h41 + 8'($urandom_range(0, 2)));
      runCase(-1, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
